// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker
//   Turns PS/2 receiver bytes into an absolute, clamped cursor position and
//   button state for the VGA pixel generator. After reset it sends the
//   "enable data reporting" command (0xF4) and waits for the 0xFA ack. Then
//   it assembles 3-byte movement packets and applies the signed deltas.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous, active-high reset
//   rx_data    in   [7:0] received byte, valid with rx_done
//   rx_done    in   one-cycle strobe, received byte available
//   tx_done    in   one-cycle strobe, transmitter finished a byte
//   tx_start   out  one-cycle request to transmit tx_data
//   tx_data    out  [7:0] command byte (always 0xF4)
//   mouse_x    out  [9:0] cursor X, 0..X_MAX
//   mouse_y    out  [9:0] cursor Y, 0..Y_MAX, 0 = top of screen
//   mouse_btn  out  [2:0] buttons: [0] left, [1] right, [2] middle
//   pkt_valid  out  one-cycle pulse when a packet has been applied
//
// Build option:
//   PS2_MOUSE_SYNC_CHECK_EN  when defined, a byte with bit3=0 is dropped when
//                            a packet's first byte is expected, which lets the
//                            tracker resynchronise to packet boundaries.

module ps2_mouse_tracker #(
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479,
    parameter int X_INIT  = 320,
    parameter int Y_INIT  = 240,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [9:0] mouse_x,
    output logic [9:0] mouse_y,
    output logic [2:0] mouse_btn,
    output logic       pkt_valid
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [9:0]      X_HI     = 10'(X_MAX);
    localparam logic [9:0]      Y_HI     = 10'(Y_MAX);
    localparam logic [7:0]      CMD_EN   = 8'hF4;
    localparam logic [7:0]      ACK      = 8'hFA;

`ifdef PS2_MOUSE_SYNC_CHECK_EN
    localparam bit SYNC_CHK = 1'b1;
`else
    localparam bit SYNC_CHK = 1'b0;
`endif

    typedef enum logic [2:0] {
        SEND,
        WAIT_TX,
        WAIT_ACK,
        B0,
        B1,
        B2,
        UPD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       byte0;
    logic [7:0]       dx;
    logic [7:0]       dy;

    logic signed [10:0] dx_s;
    logic signed [10:0] dy_s;
    logic signed [10:0] x_sum;
    logic signed [10:0] y_sum;
    logic               cnt_hit;
    logic               b0_ok;

    // Saturate a signed candidate position into 0..hi.
    function automatic logic [9:0] clamp(input logic signed [10:0] v,
                                         input logic [9:0] hi);
        if (v < 11'sd0)
            return 10'd0;
        else if (v > $signed({1'b0, hi}))
            return hi;
        else
            return v[9:0];
    endfunction

    // 9-bit deltas {sign, byte} sign-extended to the 11-bit working width.
    assign dx_s  = {{2{byte0[4]}}, byte0[4], dx};
    assign dy_s  = {{2{byte0[5]}}, byte0[5], dy};
    assign x_sum = $signed({1'b0, mouse_x}) + dx_s;
    // PS/2 Y grows upward, screen Y grows downward.
    assign y_sum = $signed({1'b0, mouse_y}) - dy_s;

    assign cnt_hit = (cnt == CNT_LAST);
    // With the sync check, a first byte must carry the always-one bit3.
    assign b0_ok   = !SYNC_CHK || rx_data[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEND;
            cnt       <= '0;
            tx_start  <= 1'b0;
            tx_data   <= CMD_EN;
            mouse_x   <= 10'(X_INIT);
            mouse_y   <= 10'(Y_INIT);
            mouse_btn <= 3'd0;
            pkt_valid <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            pkt_valid <= 1'b0;
            case (state)
                SEND: begin
                    tx_start <= 1'b1;
                    tx_data  <= CMD_EN;
                    cnt      <= '0;
                    state    <= WAIT_TX;
                end
                WAIT_TX: begin
                    // Any received byte here is ignored.
                    if (tx_done) begin
                        cnt   <= '0;
                        state <= WAIT_ACK;
                    end else if (cnt_hit) begin
                        cnt   <= '0;
                        state <= SEND;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_ACK: begin
                    if (rx_done) begin
                        cnt   <= '0;
                        state <= (rx_data == ACK) ? B0 : SEND;
                    end else if (cnt_hit) begin
                        cnt   <= '0;
                        state <= SEND;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                B0: begin
                    cnt <= '0;
                    if (rx_done && b0_ok) begin
                        byte0 <= rx_data;
                        state <= B1;
                    end
                end
                B1: begin
                    if (rx_done) begin
                        dx    <= rx_data;
                        cnt   <= '0;
                        state <= B2;
                    end else if (cnt_hit) begin
                        // Partial packet abandoned; outputs untouched.
                        cnt   <= '0;
                        state <= B0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                B2: begin
                    if (rx_done) begin
                        dy    <= rx_data;
                        cnt   <= '0;
                        state <= UPD;
                    end else if (cnt_hit) begin
                        cnt   <= '0;
                        state <= B0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                UPD: begin
                    if (!byte0[6])
                        mouse_x <= clamp(x_sum, X_HI);
                    if (!byte0[7])
                        mouse_y <= clamp(y_sum, Y_HI);
                    mouse_btn <= byte0[2:0];
                    pkt_valid <= 1'b1;
                    cnt       <= '0;
                    // A byte landing during the update starts the next packet.
                    if (rx_done && b0_ok) begin
                        byte0 <= rx_data;
                        state <= B1;
                    end else begin
                        state <= B0;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= SEND;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// tb_ps2_mouse_tracker
//   Self-checking bench for ps2_mouse_tracker. A packet-level reference model
//   (plain integer arithmetic with clamping) tracks the expected cursor and
//   buttons; directed sequences cover init, ack retry, clamping, overflow,
//   timeout, back-to-back packets, mid-packet reset and the optional
//   PS2_MOUSE_SYNC_CHECK_EN behaviour, followed by random packets.

module tb_ps2_mouse_tracker;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic [2:0] mouse_btn;
    logic       pkt_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int pkt_cnt = 0;
    int tx_cnt  = 0;

    // Reference model state
    int mx, my, mb;

    ps2_mouse_tracker #(
        .X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .tx_done(tx_done),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .mouse_x(mouse_x),
        .mouse_y(mouse_y),
        .mouse_btn(mouse_btn),
        .pkt_valid(pkt_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pkt_valid === 1'b1) pkt_cnt++;
        if (tx_start === 1'b1) tx_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void model_apply(input bit [7:0] b0, input bit [7:0] b1, input bit [7:0] b2);
        int dxv, dyv;
        dxv = b0[4] ? int'(b1) - 256 : int'(b1);
        dyv = b0[5] ? int'(b2) - 256 : int'(b2);
        if (!b0[6]) mx = clampi(mx + dxv, 639);
        if (!b0[7]) my = clampi(my - dyv, 479);
        mb = int'(b0[2:0]);
    endfunction

    task automatic chk_pos(input string tag);
        chk({tag, "_x"}, 32'(mouse_x), mx);
        chk({tag, "_y"}, 32'(mouse_y), my);
        chk({tag, "_btn"}, 32'(mouse_btn), mb);
    endtask

    task automatic ack_handshake();
        tick(2);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick(2);
        send_byte(8'hFA);
        tick();
    endtask

    task automatic reset_init();
        rst     = 1'b1;
        rx_done = 1'b0;
        tx_done = 1'b0;
        tick(2);
        chk("rst_x", 32'(mouse_x), 320);
        chk("rst_y", 32'(mouse_y), 240);
        chk("rst_btn", 32'(mouse_btn), 0);
        chk("rst_pv", 32'(pkt_valid), 0);
        chk("rst_txs", 32'(tx_start), 0);
        chk("rst_txd", 32'(tx_data), 32'hF4);
        mx = 320; my = 240; mb = 0;
        rst = 1'b0;
        tick();
        chk("init_txs_hi", 32'(tx_start), 1);
        chk("init_txd", 32'(tx_data), 32'hF4);
        tick();
        chk("init_txs_lo", 32'(tx_start), 0);
        ack_handshake();
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        tick($urandom_range(0, 3));
        send_byte(b1);
        tick($urandom_range(0, 3));
        send_byte(b2);
        model_apply(b0, b1, b2);
        chk("pv_early", 32'(pkt_valid), 0);
        tick();
        chk("pv_hi", 32'(pkt_valid), 1);
        chk_pos("pkt");
        tick();
        chk("pv_lo", 32'(pkt_valid), 0);
        chk_pos("hold");
    endtask

    initial begin
        int p0, t0;
        logic [7:0] r0, r1, r2;
        rst = 1'b1; rx_done = 1'b0; tx_done = 1'b0; rx_data = 8'h00;
        mx = 320; my = 240; mb = 0;

        reset_init();

        // Overflow and buttons, then plain movement
        send_pkt(8'h4A, 8'h10, 8'h10);
        send_pkt(8'h09, 8'h05, 8'h03);

        // Clamping in both X directions
        reset_init();
        repeat (3) send_pkt(8'h18, 8'h80, 8'h00);
        repeat (6) send_pkt(8'h08, 8'h7F, 8'h00);
        // Y clamps at both ends
        repeat (3) send_pkt(8'h08, 8'h00, 8'hFF);
        repeat (4) send_pkt(8'h28, 8'h00, 8'h01);

        // Ack retry: a NAK in WAIT_ACK re-issues the command
        rst = 1'b1;
        tick(2);
        mx = 320; my = 240; mb = 0;
        t0 = tx_cnt;
        rst = 1'b0;
        tick(2);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick(2);
        send_byte(8'hFE);
        tick(3);
        chk("retry_txcnt", 32'(tx_cnt - t0), 2);
        chk("retry_txd", 32'(tx_data), 32'hF4);
        ack_handshake();
        send_pkt(8'h0C, 8'h03, 8'h04);

        // Timeout discards a stalled partial packet
        p0 = pkt_cnt;
        send_byte(8'h09);
        tick(TO + 2);
        chk_pos("to_hold");
        send_pkt(8'h08, 8'h01, 8'h00);
        chk("to_pktcnt", 32'(pkt_cnt - p0), 1);

        // Byte arriving during the update starts the next packet
        p0 = pkt_cnt;
        send_byte(8'h19); send_byte(8'h10); send_byte(8'h20);
        send_byte(8'h0A); send_byte(8'h07); send_byte(8'hF9);
        model_apply(8'h19, 8'h10, 8'h20);
        model_apply(8'h0A, 8'h07, 8'hF9);
        tick(3);
        chk("b2b_pktcnt", 32'(pkt_cnt - p0), 2);
        chk_pos("b2b");

        // Resynchronisation stream
        p0 = pkt_cnt;
        send_byte(8'h05); send_byte(8'h08); send_byte(8'h02); send_byte(8'h00);
        tick(2);
`ifdef PS2_MOUSE_SYNC_CHECK_EN
        model_apply(8'h08, 8'h02, 8'h00);
        chk_pos("sync");
        chk("sync_pktcnt", 32'(pkt_cnt - p0), 1);
`else
        model_apply(8'h05, 8'h08, 8'h02);
        chk_pos("nosync");
        send_byte(8'h00); send_byte(8'h00);
        model_apply(8'h00, 8'h00, 8'h00);
        tick(2);
        chk_pos("nosync_flush");
        chk("nosync_pktcnt", 32'(pkt_cnt - p0), 2);
`endif

        // Reset in the middle of a packet
        send_byte(8'h08);
        send_byte(8'h10);
        reset_init();
        send_pkt(8'h08, 8'h01, 8'h01);

        // Random packets
        for (int i = 0; i < 60; i++) begin
            r0 = 8'($urandom);
            r0[3] = 1'b1;
            if ($urandom_range(0, 3) != 0) r0[7:6] = 2'b00;
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            send_pkt(r0, r1, r2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
